// File: rtl/network_pkg.sv
// Shared types and helpers for the network result path: lane geometry, sync FSM states,
// and the saturating arithmetic shift used to rescale conv results.
package network_pkg;

  localparam int unsigned NET_W      = 16;
  localparam int unsigned NET_D      = 8;
  localparam int unsigned NET_SHIFT  = 2;
  localparam int unsigned NET_LANES  = 4;
  localparam int unsigned STAT_W     = 16;

  typedef enum logic {
    WAIT_EDGE = 1'b0,
    HELD      = 1'b1
  } sync_state_e;

  // x (sign-extended to 32 bits) <<< shift, clamped to the signed range of a w-bit value
  function automatic logic signed [31:0] sat_shift(input logic signed [31:0] x,
                                                   input int unsigned       shift,
                                                   input int unsigned       w);
    logic signed [63:0] wide;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    wide = 64'(x) <<< shift;
    hi   = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo   = -hi - 64'sd1;
    if (wide > hi) begin
      return 32'(hi);
    end else if (wide < lo) begin
      return 32'(lo);
    end else begin
      return 32'(wide);
    end
  endfunction

endpackage

// File: rtl/network_output_sync_rising_edge_detect.sv
// Registers a level and flags the cycle in which it first goes high.
module rising_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise_c
);

  logic prev_level;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_level <= 1'b0;
    end else begin
      prev_level <= level;
    end
  end

  assign rise_c = level & ~prev_level;

endmodule

// File: rtl/network_output_sync.sv
// Re-times packed conv results onto the sample_clk grid, scaling and saturating lanes 0..3.
// Optional latency/overrun statistics ports are built when NETWORK_OUTPUT_SYNC_STATS_EN is defined.
module network_output_sync
  import network_pkg::*;
#(
  parameter int unsigned W     = NET_W,
  parameter int unsigned D     = NET_D,
  parameter int unsigned SHIFT = NET_SHIFT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sample_clk,
  input  logic [D*W-1:0] packed_in,
  input  logic           in_v,
  output logic [W-1:0]   sample_out0,
  output logic [W-1:0]   sample_out1,
  output logic [W-1:0]   sample_out2,
  output logic [W-1:0]   sample_out3,
  output logic           overrun
`ifdef NETWORK_OUTPUT_SYNC_STATS_EN
  ,
  output logic [STAT_W-1:0] lat_last,
  output logic [STAT_W-1:0] lat_max,
  output logic [STAT_W-1:0] overrun_count
`endif
);

  localparam int unsigned LANES = NET_LANES;

  if (D < LANES) begin : g_bad_lanes
    $error("network_output_sync: D must be at least 4");
  end

  sync_state_e                state_q, state_d;
  logic [LANES-1:0][W-1:0]    hold_q, hold_d;
  logic [LANES-1:0][W-1:0]    out_q, out_d;
  logic [LANES-1:0][W-1:0]    in_lane;
  logic                       overrun_q, overrun_d;
  logic                       rise_c;

  function automatic logic [W-1:0] scale_lane(input logic [W-1:0] x);
    return W'(sat_shift(32'(signed'(x)), SHIFT, W));
  endfunction

  rising_edge_detect u_edge (
    .clk    (clk),
    .rst    (rst),
    .level  (sample_clk),
    .rise_c (rise_c)
  );

  // lane0 occupies the top W bits of packed_in
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign in_lane[k] = packed_in[(D-k)*W-1 -: W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WAIT_EDGE;
      hold_q    <= '0;
      out_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      out_q     <= out_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    out_d     = out_q;
    overrun_d = overrun_q;
    if (rise_c && in_v) begin
      // A result arriving on the edge itself belongs to the period just ending
      for (int k = 0; k < LANES; k++) out_d[k] = scale_lane(in_lane[k]);
      overrun_d = 1'b0;
      state_d   = WAIT_EDGE;
    end else if (rise_c) begin
      case (state_q)
        HELD: begin
          for (int k = 0; k < LANES; k++) out_d[k] = scale_lane(hold_q[k]);
          overrun_d = 1'b0;
        end
        default: overrun_d = 1'b1;
      endcase
      state_d = WAIT_EDGE;
    end else if (in_v) begin
      hold_d  = in_lane;
      state_d = HELD;
    end
  end

  assign sample_out0 = out_q[0];
  assign sample_out1 = out_q[1];
  assign sample_out2 = out_q[2];
  assign sample_out3 = out_q[3];
  assign overrun     = overrun_q;

`ifdef NETWORK_OUTPUT_SYNC_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic [STAT_W-1:0] lat_cnt_q;
  logic [STAT_W-1:0] lat_now_c;

  assign lat_now_c = rise_c ? '0 : lat_cnt_q;

  // lat_cnt_q holds clk cycles elapsed since the most recent rise
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt_q     <= '0;
      lat_last      <= '0;
      lat_max       <= '0;
      overrun_count <= '0;
    end else begin
      if (rise_c) begin
        lat_cnt_q <= STAT_W'(1);
      end else if (lat_cnt_q != STAT_MAX) begin
        lat_cnt_q <= lat_cnt_q + STAT_W'(1);
      end
      if (in_v) begin
        lat_last <= lat_now_c;
        if (lat_now_c > lat_max) begin
          lat_max <= lat_now_c;
        end
      end
      if (rise_c && !in_v && (state_q == WAIT_EDGE) && (overrun_count != STAT_MAX)) begin
        overrun_count <= overrun_count + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_network_output_sync.sv
// Directed bench for network_output_sync: period re-timing, saturation, overrun and reset cases.
// Statistics checks are included when NETWORK_OUTPUT_SYNC_STATS_EN is defined.
module tb_network_output_sync;

  localparam int unsigned W = 16;
  localparam int unsigned D = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           sample_clk = 1'b0;
  logic [D*W-1:0] packed_in = '0;
  logic           in_v = 1'b0;
  logic [W-1:0]   sample_out0, sample_out1, sample_out2, sample_out3;
  logic           overrun;
`ifdef NETWORK_OUTPUT_SYNC_STATS_EN
  logic [15:0]    lat_last, lat_max, overrun_count;
`endif

  int tests = 0;
  int fails = 0;

  network_output_sync dut (
    .clk         (clk),
    .rst         (rst),
    .sample_clk  (sample_clk),
    .packed_in   (packed_in),
    .in_v        (in_v),
    .sample_out0 (sample_out0),
    .sample_out1 (sample_out1),
    .sample_out2 (sample_out2),
    .sample_out3 (sample_out3),
    .overrun     (overrun)
`ifdef NETWORK_OUTPUT_SYNC_STATS_EN
    ,
    .lat_last      (lat_last),
    .lat_max       (lat_max),
    .overrun_count (overrun_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Lanes 4..7 carry junk that must never reach the outputs
  function automatic logic [D*W-1:0] pack(input logic [15:0] l0, input logic [15:0] l1,
                                          input logic [15:0] l2, input logic [15:0] l3);
    return {l0, l1, l2, l3, 16'h7FFF, 16'h8000, 16'h1234, 16'hDEAD};
  endfunction

  task automatic send(input logic [D*W-1:0] v);
    packed_in = v;
    in_v = 1'b1;
    tick();
    in_v = 1'b0;
  endtask

  // Rising edge of sample_clk sampled on the next clk; outputs observable right after
  task automatic rise();
    sample_clk = 1'b1;
    tick();
    sample_clk = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    check("reset_out0", 32'(sample_out0), 32'h0000);
    check("reset_out3", 32'(sample_out3), 32'h0000);
    check("reset_overrun", 32'(overrun), 32'h0);

    // basic scaling of a mid-period result
    repeat (3) tick();
    send(pack(16'h0100, 16'h0000, 16'h0005, 16'hFFFF));
    repeat (4) tick();
    check("t1_out0_before_rise", 32'(sample_out0), 32'h0000);
    rise();
    check("t1_out0", 32'(sample_out0), 32'h0400);
    check("t1_out2", 32'(sample_out2), 32'h0014);
    check("t1_out3", 32'(sample_out3), 32'hFFFC);
    check("t1_overrun", 32'(overrun), 32'h0);

    // saturation at both ends plus exact-fit boundaries
    repeat (3) tick();
    send(pack(16'h3000, 16'hC000, 16'h1FFF, 16'hE000));
    repeat (2) tick();
    rise();
    check("t2_pos_sat", 32'(sample_out0), 32'h7FFF);
    check("t2_neg_sat", 32'(sample_out1), 32'h8000);
    check("t2_pos_fit", 32'(sample_out2), 32'h7FFC);
    check("t2_neg_fit", 32'(sample_out3), 32'h8000);

    // result followed by two empty periods
    repeat (2) tick();
    send(pack(16'h0010, 16'h0000, 16'h0000, 16'h0000));
    repeat (2) tick();
    rise();
    check("t3_out0", 32'(sample_out0), 32'h0040);
    check("t3_overrun0", 32'(overrun), 32'h0);
    repeat (5) tick();
    rise();
    check("t3_out0_hold1", 32'(sample_out0), 32'h0040);
    check("t3_overrun1", 32'(overrun), 32'h1);
    repeat (5) tick();
    rise();
    check("t3_out0_hold2", 32'(sample_out0), 32'h0040);
    check("t3_overrun2", 32'(overrun), 32'h1);

    // result coincident with the edge bypasses the hold register
    repeat (3) tick();
    packed_in = pack(16'h0002, 16'h0000, 16'h0000, 16'h0000);
    in_v = 1'b1;
    rise();
    in_v = 1'b0;
    check("t4_out0", 32'(sample_out0), 32'h0008);
    check("t4_overrun", 32'(overrun), 32'h0);
    repeat (4) tick();
    rise();
    check("t4_no_double_use", 32'(overrun), 32'h1);
    check("t4_out0_static", 32'(sample_out0), 32'h0008);

    // last result in a period wins; reset discards a held result
    repeat (2) tick();
    send(pack(16'h0001, 16'h0000, 16'h0000, 16'h0000));
    tick();
    send(pack(16'h0003, 16'h0000, 16'h0000, 16'h0000));
    tick();
    rise();
    check("t5_overwrite", 32'(sample_out0), 32'h000C);
    check("t5_overrun", 32'(overrun), 32'h0);
    tick();
    send(pack(16'h0005, 16'h0000, 16'h0000, 16'h0000));
    do_reset();
    check("t5_rst_out0", 32'(sample_out0), 32'h0000);
    check("t5_rst_overrun", 32'(overrun), 32'h0);
    repeat (3) tick();
    rise();
    check("t5_after_rst_overrun", 32'(overrun), 32'h1);
    check("t5_after_rst_out0", 32'(sample_out0), 32'h0000);

    // sample_clk held high gives no further edges
    sample_clk = 1'b1;
    tick();
    send(pack(16'h0007, 16'h0000, 16'h0000, 16'h0000));
    repeat (6) tick();
    check("t7_held_high_static", 32'(sample_out0), 32'h0000);
    sample_clk = 1'b0;
    tick();
    rise();
    check("t7_release_out0", 32'(sample_out0), 32'h001C);
    check("t7_release_overrun", 32'(overrun), 32'h0);

`ifdef NETWORK_OUTPUT_SYNC_STATS_EN
    do_reset();
    check("s_rst_lat_last", 32'(lat_last), 32'h0);
    check("s_rst_lat_max", 32'(lat_max), 32'h0);
    check("s_rst_overrun_count", 32'(overrun_count), 32'h0);
    tick();
    send(pack(16'h0001, 16'h0000, 16'h0000, 16'h0000));
    repeat (3) tick();
    for (int p = 0; p < 3; p++) begin
      rise();
      repeat (36) tick();
      send(pack(16'h0002, 16'h0000, 16'h0000, 16'h0000));
      repeat (5) tick();
    end
    rise();
    check("s_lat_last", 32'(lat_last), 32'd37);
    check("s_lat_max", 32'(lat_max), 32'd37);
    check("s_no_overrun", 32'(overrun_count), 32'd0);
    repeat (4) tick();
    rise();
    check("s_overrun_count", 32'(overrun_count), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
